seq_mag_comp: RTL and testbench

SEQ_MAG_COMP -- requirements
Module: seq_mag_comp

---
 rtl/comp_pkg.sv | 16 +
 rtl/mod_bit_comp.sv | 18 +
 rtl/mod_digit_comp.sv | 42 ++++
 rtl/seq_mag_comp.sv | 141 ++++++++++++++
 tb/tb_seq_mag_comp.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/comp_pkg.sv
// Shared definitions for the sequential magnitude comparator: FSM state
// encoding and the digit-count helper.
package comp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  // Number of digit steps needed to walk a WIDTH-bit operand DIGIT bits at a time.
  function automatic int comp_cycles(input int width, input int digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/mod_bit_comp.sv
// One-bit magnitude comparator slice with GT/EQ/LT cascade. A more-significant
// decision (eq_in low) passes through untouched.
module mod_bit_comp (
  input  logic a,
  input  logic b,
  input  logic gt_in,
  input  logic eq_in,
  input  logic lt_in,
  output logic gt,
  output logic eq,
  output logic lt
);

  assign gt = gt_in | (eq_in & a & ~b);
  assign lt = lt_in | (eq_in & ~a & b);
  assign eq = eq_in & ~(a ^ b);

endmodule

// File: rtl/mod_digit_comp.sv
// DIGIT-wide combinational magnitude slice: a chain of one-bit slices walked
// from the digit MSB down to its LSB, cascade in at the top and out at the bottom.
module mod_digit_comp #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             gt_in,
  input  logic             eq_in,
  input  logic             lt_in,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  // Index DIGIT is the incoming cascade; index 0 is the slice result.
  logic [DIGIT:0] g_c;
  logic [DIGIT:0] e_c;
  logic [DIGIT:0] l_c;

  assign g_c[DIGIT] = gt_in;
  assign e_c[DIGIT] = eq_in;
  assign l_c[DIGIT] = lt_in;

  for (genvar i = DIGIT - 1; i >= 0; i--) begin : g_bit
    mod_bit_comp u_bit (
      .a     (a[i]),
      .b     (b[i]),
      .gt_in (g_c[i+1]),
      .eq_in (e_c[i+1]),
      .lt_in (l_c[i+1]),
      .gt    (g_c[i]),
      .eq    (e_c[i]),
      .lt    (l_c[i])
    );
  end

  assign gt = g_c[0];
  assign eq = e_c[0];
  assign lt = l_c[0];

endmodule

// File: rtl/seq_mag_comp.sv
// Sequential magnitude comparator: compares two WIDTH-bit operands MSB-first,
// DIGIT bits per cycle, with cascade inputs, optional two's-complement mode and
// optional early termination once the outcome is known.
//
// Handshake: START is sampled only in IDLE; an accepted START latches all
// operands and the cascade, clears GT/EQ/LT and enters RUN (BUSY high).
// DONE is a single-cycle pulse coinciding with the first cycle GT/EQ/LT carry
// the new result; that cycle is IDLE, so a START there is accepted.
module seq_mag_comp
  import comp_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DIGIT      = 2,
  parameter int EARLY_EXIT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             SIGNED,
  input  logic             GT_IN,
  input  logic             EQ_IN,
  input  logic             LT_IN,
  output logic             BUSY,
  output logic             DONE,
  output logic             GT,
  output logic             EQ,
  output logic             LT,
  output state_e           dbg_state
);

  if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_params
    $error("seq_mag_comp: WIDTH must be a positive multiple of DIGIT");
  end

  localparam int CYCLES = comp_cycles(WIDTH, DIGIT);
  localparam int CNT_W  = $clog2(CYCLES + 1);

  state_e           state;
  state_e           state_nx;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sign_mask;
  logic [CNT_W-1:0] cnt;
  logic             run_gt;
  logic             run_eq;
  logic             run_lt;
  logic             d_gt;
  logic             d_eq;
  logic             d_lt;
  logic             last_digit;
  logic             decided;

  // Flipping the sign bit of both operands maps two's-complement order onto
  // unsigned order, so the same magnitude chain serves both modes.
  assign sign_mask = WIDTH'(SIGNED) << (WIDTH - 1);

  mod_digit_comp #(.DIGIT(DIGIT)) u_digit (
    .a     (a_sh[WIDTH-1 -: DIGIT]),
    .b     (b_sh[WIDTH-1 -: DIGIT]),
    .gt_in (run_gt),
    .eq_in (run_eq),
    .lt_in (run_lt),
    .gt    (d_gt),
    .eq    (d_eq),
    .lt    (d_lt)
  );

  assign last_digit = (cnt == CNT_W'(CYCLES - 1));
  assign decided    = (EARLY_EXIT != 0) && !d_eq;
  assign BUSY       = (state == RUN);
  assign dbg_state  = state;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state: RUN ends after the last digit, or as soon as the running
  // result is decided when early exit is enabled.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (START) state_nx = RUN;
      RUN:     if (last_digit || decided) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: operand latch and shift, running cascade, result and DONE registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      cnt    <= '0;
      run_gt <= 1'b0;
      run_eq <= 1'b0;
      run_lt <= 1'b0;
      DONE   <= 1'b0;
      GT     <= 1'b0;
      EQ     <= 1'b0;
      LT     <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            a_sh   <= A ^ sign_mask;
            b_sh   <= B ^ sign_mask;
            cnt    <= '0;
            run_gt <= GT_IN;
            run_eq <= EQ_IN;
            run_lt <= LT_IN;
            GT     <= 1'b0;
            EQ     <= 1'b0;
            LT     <= 1'b0;
          end
        end
        RUN: begin
          run_gt <= d_gt;
          run_eq <= d_eq;
          run_lt <= d_lt;
          a_sh   <= a_sh << DIGIT;
          b_sh   <= b_sh << DIGIT;
          cnt    <= cnt + CNT_W'(1);
        end
        FIN: begin
          GT   <= run_gt;
          EQ   <= run_eq;
          LT   <= run_lt;
          DONE <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mag_comp.sv
// Bench for seq_mag_comp (WIDTH=8, DIGIT=2): one instance without early exit
// and one with it, driven by directed steps followed by random operations.
module tb_seq_mag_comp;

  localparam int W   = 8;
  localparam int D   = 2;
  localparam int CYC = W / D;

  // Clock and reset.
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [W-1:0] a_in, b_in;
  logic         sgn_in, gi_in, ei_in, li_in;
  logic         start0, start1;
  logic         busy0, done0, gt0, eq0, lt0;
  logic         busy1, done1, gt1, eq1, lt1;
  logic [1:0]   st0, st1;

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];

  seq_mag_comp #(.WIDTH(W), .DIGIT(D), .EARLY_EXIT(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .START(start0), .A(a_in), .B(b_in),
    .SIGNED(sgn_in), .GT_IN(gi_in), .EQ_IN(ei_in), .LT_IN(li_in),
    .BUSY(busy0), .DONE(done0), .GT(gt0), .EQ(eq0), .LT(lt0), .dbg_state(st0)
  );

  seq_mag_comp #(.WIDTH(W), .DIGIT(D), .EARLY_EXIT(1)) u_dut_ee (
    .clk(clk), .rst_n(rst_n), .START(start1), .A(a_in), .B(b_in),
    .SIGNED(sgn_in), .GT_IN(gi_in), .EQ_IN(ei_in), .LT_IN(li_in),
    .BUSY(busy1), .DONE(done1), .GT(gt1), .EQ(eq1), .LT(lt1), .dbg_state(st1)
  );

  // Reference: plain integer comparison, cascade short-circuits when EQ_IN=0.
  function automatic logic [2:0] ref_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic sgn, input logic gi, input logic ei,
                                         input logic li);
    int va, vb;
    if (!ei) return {gi, 1'b0, li};
    va = sgn ? int'($signed(a)) : int'(a);
    vb = sgn ? int'($signed(b)) : int'(b);
    if (va > vb) return 3'b100;
    if (va < vb) return 3'b001;
    return 3'b010;
  endfunction

  // Reference DONE latency in cycles after the accepting edge.
  function automatic int ref_lat(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ei, input logic early);
    if (!early) return CYC + 1;
    if (!ei) return 2;
    for (int k = 0; k < CYC; k++) begin
      if (((a >> (W - D * (k + 1))) & 8'h03) != ((b >> (W - D * (k + 1))) & 8'h03))
        return k + 2;
    end
    return CYC + 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] outs(input int dsel);
    return (dsel == 0) ? {busy0, done0, gt0, eq0, lt0} : {busy1, done1, gt1, eq1, lt1};
  endfunction

  // Driver: issue one operation and wait for its DONE. Called just after a
  // rising edge; returns just after the DONE edge (an IDLE cycle).
  task automatic do_op(input int dsel, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sgn, input logic gi, input logic ei, input logic li,
                       input string tag);
    int lat;
    int exp_lat;
    logic [4:0] o;
    logic [2:0] e;
    a_in = a; b_in = b; sgn_in = sgn; gi_in = gi; ei_in = ei; li_in = li;
    if (dsel == 0) start0 = 1'b1;
    else           start1 = 1'b1;
    exp_q.push_back(ref_cmp(a, b, sgn, gi, ei, li));
    exp_lat = ref_lat(a, b, ei, dsel == 1);
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0;
    // Scramble inputs: the DUT must be working from its latched copies.
    a_in = W'($urandom); b_in = W'($urandom); sgn_in = ~sgn; gi_in = ~gi; ei_in = ~ei; li_in = ~li;
    o = outs(dsel);
    check({tag, " busy_run"}, 32'(o[4]), 32'd1);
    check({tag, " cleared"}, 32'(o[2:0]), 32'd0);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      o = outs(dsel);
    end while (!o[3] && lat < 40);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    e = exp_q.pop_front();
    check({tag, " result"}, 32'(o[2:0]), 32'(e));
    check({tag, " busy_done"}, 32'(o[4]), 32'd0);
  endtask

  initial begin
    int lat;
    int ndone;
    logic [2:0] casc;
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
    a_in = '0; b_in = '0; sgn_in = 1'b0; gi_in = 1'b0; ei_in = 1'b1; li_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset outs0", 32'(outs(0)), 32'd0);
    check("reset outs1", 32'(outs(1)), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed operations; consecutive calls also exercise back-to-back starts.
    do_op(0, 8'h80, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0, "unsigned_80_7f");
    do_op(0, 8'h80, 8'h7F, 1'b1, 1'b0, 1'b1, 1'b0, "signed_80_7f");
    do_op(0, 8'h5A, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, "equal_5a");
    do_op(0, 8'h5A, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, "cascade_gt");
    do_op(0, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, "cascade_lt");
    @(posedge clk); #1;
    check("single_pulse", 32'(done0), 32'd0);

    do_op(1, 8'h40, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, "early_40_00");
    do_op(1, 8'h12, 8'h13, 1'b0, 1'b0, 1'b1, 1'b0, "early_last_digit");
    do_op(1, 8'h33, 8'h33, 1'b0, 1'b0, 1'b1, 1'b0, "early_equal");
    do_op(1, 8'h33, 8'h34, 1'b0, 1'b1, 1'b0, 1'b0, "early_cascade");
    @(posedge clk); #1;

    // START during RUN is ignored.
    a_in = 8'h11; b_in = 8'h22; sgn_in = 1'b0; gi_in = 1'b0; ei_in = 1'b1; li_in = 1'b0;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    @(posedge clk); #1;
    a_in = 8'hFF; b_in = 8'h00; start0 = 1'b1;
    lat = 1;
    @(posedge clk); #1;
    start0 = 1'b0;
    lat++;
    while (!done0 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("ignore_start latency", 32'(lat), 32'(CYC + 1));
    check("ignore_start result", 32'({gt0, eq0, lt0}), 32'(ref_cmp(8'h11, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0)));
    ndone = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done0) ndone++;
    end
    check("ignore_start extra_done", 32'(ndone), 32'd0);

    // Reset in the middle of a comparison aborts it.
    a_in = 8'h33; b_in = 8'h44; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort outs", 32'(outs(0)), 32'd0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    ndone = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done0) ndone++;
    end
    check("abort no_done", 32'(ndone), 32'd0);
    do_op(0, 8'h33, 8'h44, 1'b0, 1'b0, 1'b1, 1'b0, "after_abort");

    // Random operations on both instances.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0:       casc = 3'b100;
        1:       casc = 3'b001;
        default: casc = 3'b010;
      endcase
      do_op(int'($urandom_range(0, 1)), W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
            casc[2], casc[1], casc[0], $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
